uart_tx_arbiter: RTL and testbench

- Shares one UART byte transmitter among N_REQ byte sources.
- Round-robin arbitration with per-requester frame lock: a multi-byte frame goes out uninterrupted.
- Drives the transmitter's one-cycle send_en/data_byte interface. Waits for its one-cycle tx_done pulse, then enforces an inter-byte idle gap.
- A watchdog flags a transmitter that never completes.

---
 rtl/uart_tx_arbiter.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among N_REQ sources.
// Frames are locked to their requester; a watchdog recovers from a stuck transmitter.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int GAP_CYC = 16,
  parameter int TO_CYC  = 60000,
  localparam int IDW    = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_send_en,
  output logic [7:0]         tx_data,
  input  logic               tx_done,
  output logic               busy,
  output logic [IDW-1:0]     grant_id,
  output logic               err_timeout
);

  localparam int GAPN = (GAP_CYC == 0) ? 1 : GAP_CYC;
  localparam logic [15:0] GAP_LAST = 16'(GAPN - 1);
  localparam logic [15:0] TO_LAST  = 16'(TO_CYC - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, GAP} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] grantId_q, grantId_d;
  logic [IDW-1:0] rrPtr_q, rrPtr_d;
  logic           lock_q, lock_d;
  logic [15:0]    timer_q, timer_d;
  logic [15:0]    gapCnt_q, gapCnt_d;
  logic [7:0]     txData_q, txData_d;
  logic           sendEn_q, sendEn_d;
  logic           err_q, err_d;

  logic           found;
  logic [IDW-1:0] winner;
  int             idx;
  logic [7:0]     reqByte [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign reqByte[g] = req_data[8*g +: 8];
  end

  // Scan starts just after the last winner so every requester gets a turn.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(rrPtr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[IDW'(idx)]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grantId_d = grantId_q;
    rrPtr_d   = rrPtr_q;
    lock_d    = lock_q;
    timer_d   = timer_q;
    gapCnt_d  = gapCnt_q;
    txData_d  = txData_q;
    sendEn_d  = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grantId_d = winner;
          rrPtr_d   = winner;
          timer_d   = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (req_valid[grantId_q]) begin
          txData_d = reqByte[grantId_q];
          lock_d   = ~req_last[grantId_q];
          sendEn_d = 1'b1;
          timer_d  = '0;
          state_d  = WAIT;
        end else if (timer_q == TO_LAST) begin
          err_d    = 1'b1;
          lock_d   = 1'b0;
          gapCnt_d = '0;
          state_d  = GAP;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      WAIT: begin
        timer_d = timer_q + 16'd1;
        // A completion arriving on the expiry cycle still counts as success.
        if (tx_done) begin
          gapCnt_d = '0;
          state_d  = GAP;
        end else if (timer_q == TO_LAST) begin
          err_d    = 1'b1;
          lock_d   = 1'b0;
          gapCnt_d = '0;
          state_d  = GAP;
        end
      end
      GAP: begin
        gapCnt_d = gapCnt_q + 16'd1;
        if (gapCnt_q == GAP_LAST) begin
          if (lock_q) begin
            timer_d = '0;
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grantId_q <= '0;
      rrPtr_q   <= IDW'(N_REQ - 1);
      lock_q    <= 1'b0;
      timer_q   <= '0;
      gapCnt_q  <= '0;
      txData_q  <= '0;
      sendEn_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grantId_q <= grantId_d;
      rrPtr_q   <= rrPtr_d;
      lock_q    <= lock_d;
      timer_q   <= timer_d;
      gapCnt_q  <= gapCnt_d;
      txData_q  <= txData_d;
      sendEn_q  <= sendEn_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == LOAD) req_ready[grantId_q] = 1'b1;
  end

  assign tx_send_en  = sendEn_q;
  assign tx_data     = txData_q;
  assign busy        = (state_q != IDLE);
  assign grant_id    = grantId_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: ordering, frame lock, gap timing, watchdog and reset.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_send_en;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic [1:0]  grant_id;
  logic        err_timeout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int countdown  = 0;
  int pendingIdx = -1;
  int errCount   = 0;
  int errTime    = 0;
  int n;

  logic [7:0] srcData [4][3];
  int         srcLen [4];
  int         srcPos [4];
  logic [7:0] sendData [$];
  int         sendGrant [$];
  int         sendTime [$];

  uart_tx_arbiter #(.N_REQ(4), .GAP_CYC(16), .TO_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_send_en(tx_send_en), .tx_data(tx_data),
    .tx_done(tx_done), .busy(busy), .grant_id(grant_id), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int i, input int len, input logic [7:0] b0,
                               input logic [7:0] b1, input logic [7:0] b2);
    srcData[i][0] = b0;
    srcData[i][1] = b1;
    srcData[i][2] = b2;
    srcLen[i] = len;
    srcPos[i] = 0;
    req_data[8*i +: 8] = b0;
    req_last[i]  = (len == 1);
    req_valid[i] = 1'b1;
  endtask

  task automatic advanceSource(input int i);
    srcPos[i]++;
    if (srcPos[i] >= srcLen[i]) begin
      req_valid[i] = 1'b0;
      req_last[i]  = 1'b0;
    end else begin
      req_data[8*i +: 8] = srcData[i][srcPos[i]];
      req_last[i] = (srcPos[i] == srcLen[i] - 1);
    end
  endtask

  // Models the sources and a transmitter that answers dly cycles after each send (never if dly <= 0).
  task automatic runCycles(input int cycles, input int dly);
    for (int k = 0; k < cycles; k++) begin
      tick();
      cyc++;
      if (pendingIdx >= 0) advanceSource(pendingIdx);
      pendingIdx = -1;
      tx_done = 1'b0;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) tx_done = 1'b1;
      end
      if (tx_send_en) begin
        sendData.push_back(tx_data);
        sendGrant.push_back(int'(grant_id));
        sendTime.push_back(cyc);
        countdown = (dly > 0) ? dly : -1;
      end
      for (int i = 0; i < 4; i++)
        if (req_valid[i] && req_ready[i]) pendingIdx = i;
      if (err_timeout) begin
        errCount++;
        errTime = cyc;
      end
    end
  endtask

  task automatic clearLogs;
    sendData.delete();
    sendGrant.delete();
    sendTime.delete();
  endtask

  task automatic resetDut;
    rst_n = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_done   = 1'b0;
    countdown = 0;
    pendingIdx = -1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_done   = 1'b0;
    repeat (3) tick();
    checkOutput("rst ready", 32'(req_ready), 0);
    checkOutput("rst send", 32'(tx_send_en), 0);
    checkOutput("rst data", 32'(tx_data), 0);
    checkOutput("rst busy", 32'(busy), 0);
    checkOutput("rst grant", 32'(grant_id), 0);
    checkOutput("rst err", 32'(err_timeout), 0);
    rst_n = 1'b1;
    tick();

    // Single byte: ready at +1, send at +2, then a 16-cycle gap.
    req_valid[0] = 1'b1;
    req_data[7:0] = 8'h55;
    req_last[0] = 1'b1;
    tick();
    checkOutput("t1 ready", 32'(req_ready), 32'h1);
    checkOutput("t1 early send", 32'(tx_send_en), 0);
    tick();
    checkOutput("t1 send", 32'(tx_send_en), 1);
    checkOutput("t1 data", 32'(tx_data), 32'h55);
    checkOutput("t1 ready drop", 32'(req_ready), 0);
    req_valid[0] = 1'b0;
    tick();
    checkOutput("t1 send pulse", 32'(tx_send_en), 0);
    checkOutput("t1 busy", 32'(busy), 1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    checkOutput("t1 gap len", n, 16);

    // Four single-byte requesters from a fresh pointer, then 0 and 2 again.
    resetDut();
    clearLogs();
    for (int i = 0; i < 4; i++) applyStimulus(i, 1, 8'h10 + 8'(i), 8'h00, 8'h00);
    runCycles(100, 3);
    checkOutput("t2 count", sendData.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t2 grant%0d", i), sendGrant[i], i);
      checkOutput($sformatf("t2 data%0d", i), 32'(sendData[i]), 32'h10 + i);
    end
    clearLogs();
    applyStimulus(2, 1, 8'h22, 8'h00, 8'h00);
    applyStimulus(0, 1, 8'h20, 8'h00, 8'h00);
    runCycles(60, 3);
    checkOutput("t2b count", sendData.size(), 2);
    checkOutput("t2b first", sendGrant[0], 0);
    checkOutput("t2b second", sendGrant[1], 2);

    // Locked three-byte frame on req2 holds off req0.
    clearLogs();
    applyStimulus(2, 3, 8'hA1, 8'hA2, 8'hA3);
    runCycles(4, 3);
    applyStimulus(0, 1, 8'h0B, 8'h00, 8'h00);
    runCycles(120, 3);
    checkOutput("t3 count", sendData.size(), 4);
    checkOutput("t3 g0", sendGrant[0], 2);
    checkOutput("t3 g1", sendGrant[1], 2);
    checkOutput("t3 g2", sendGrant[2], 2);
    checkOutput("t3 g3", sendGrant[3], 0);
    checkOutput("t3 d1", 32'(sendData[1]), 32'hA2);
    checkOutput("t3 d2", 32'(sendData[2]), 32'hA3);
    checkOutput("t3 d3", 32'(sendData[3]), 32'h0B);
    checkOutput("t3 spacing", sendTime[1] - sendTime[0], 21);

    // Watchdog: req1 never completes, req3 follows after the gap.
    clearLogs();
    applyStimulus(1, 1, 8'h77, 8'h00, 8'h00);
    applyStimulus(3, 1, 8'h33, 8'h00, 8'h00);
    runCycles(110, -1);
    runCycles(40, 3);
    checkOutput("t4 err count", errCount, 1);
    checkOutput("t4 err delay", errTime - sendTime[0], 100);
    checkOutput("t4 next grant", sendGrant[1], 3);
    checkOutput("t4 next data", 32'(sendData[1]), 32'h33);
    checkOutput("t4 next delay", sendTime[1] - errTime, 18);

    // Completion on the last watchdog cycle wins over the timeout.
    clearLogs();
    applyStimulus(0, 1, 8'h99, 8'h00, 8'h00);
    runCycles(140, 99);
    checkOutput("t4b err count", errCount, 1);
    checkOutput("t4b grant", sendGrant[0], 0);
    checkOutput("t4b idle", 32'(busy), 0);

    // Stray completion while idle.
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checkOutput("t4c busy", 32'(busy), 0);
    checkOutput("t4c send", 32'(tx_send_en), 0);
    checkOutput("t4c err", 32'(err_timeout), 0);
    tick();
    checkOutput("t4c busy2", 32'(busy), 0);

    // Reset in the middle of a locked req1 frame.
    clearLogs();
    applyStimulus(1, 3, 8'hC1, 8'hC2, 8'hC3);
    runCycles(4, -1);
    checkOutput("t5 pre busy", 32'(busy), 1);
    checkOutput("t5 pre grant", 32'(grant_id), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t5 busy", 32'(busy), 0);
    checkOutput("t5 grant", 32'(grant_id), 0);
    checkOutput("t5 data", 32'(tx_data), 0);
    checkOutput("t5 ready", 32'(req_ready), 0);
    resetDut();
    clearLogs();
    applyStimulus(0, 1, 8'hD0, 8'h00, 8'h00);
    applyStimulus(1, 1, 8'hD1, 8'h00, 8'h00);
    runCycles(60, 3);
    checkOutput("t5 count", sendData.size(), 2);
    checkOutput("t5 first", sendGrant[0], 0);
    checkOutput("t5 second", sendGrant[1], 1);
    checkOutput("t5 second data", 32'(sendData[1]), 32'hD1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
